round_controller: RTL

//  Game datapath sequencer for the difficulty FSM. Picks a random target sized to Max_digit and

---
 rtl/round_controller.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/round_controller.sv
// Round sequencer for the guessing game: picks LFSR targets per level, runs the
// per-level countdown, synchronises the confirm button and grades each guess.
module round_controller #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned TIMER_STEP    = 30,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned ROUNDS_TO_WIN = 5
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       confirmButton,
    input  logic [9:0] guess,
    input  logic [1:0] Max_digit,
    input  logic [1:0] WINorLOSE,
    output logic [2:0] round,
    output logic [2:0] incorrect_guesses,
    output logic [6:0] timer,
    output logic [9:0] target,
    output logic [1:0] guess_result,
    output logic       confirm_pulse
);

    localparam int unsigned     PW         = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [2:0]      ROUND_MAX  = 3'(ROUNDS_TO_WIN);
    localparam logic [6:0]      TIMER_INIT = 7'(TIMER_STEP);

    typedef enum logic [1:0] {
        ST_PICK  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    round_q, round_d;
    logic [2:0]    incorrect_q, incorrect_d;
    logic [6:0]    timer_q, timer_d;
    logic [9:0]    target_q, target_d;
    logic [1:0]    result_q, result_d;
    logic          pulse_q, pulse_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [1:0]    prev_digit_q, prev_digit_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    latched_q, latched_d;
    logic          sync1_q, sync2_q, edge_q;

    logic          lfsr_fb;
    logic          halt_now;
    logic [9:0]    sample;
    logic [9:0]    sample_lim;
    logic [6:0]    level_load;

    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign halt_now   = (state_q == ST_HALT) || (WINorLOSE != 2'b11) || (Max_digit == 2'd0);
    assign level_load = 7'(TIMER_STEP * Max_digit);

    // Target field width follows the digit count of the active level.
    always_comb begin
        sample     = lfsr_q[9:0];
        sample_lim = 10'd1000;
        case (prev_digit_q)
            2'd1: begin
                sample     = {6'd0, lfsr_q[3:0]};
                sample_lim = 10'd10;
            end
            2'd2: begin
                sample     = {3'd0, lfsr_q[6:0]};
                sample_lim = 10'd100;
            end
            default: begin
                sample     = lfsr_q[9:0];
                sample_lim = 10'd1000;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        incorrect_d  = incorrect_q;
        timer_d      = timer_q;
        target_d     = target_q;
        result_d     = result_q;
        prev_digit_d = prev_digit_q;
        presc_d      = presc_q;
        latched_d    = latched_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_fb};
        pulse_d      = sync2_q & ~edge_q;

        if (halt_now) begin
            state_d = ST_HALT;
            pulse_d = pulse_q;
        end else if (Max_digit != prev_digit_q) begin
            prev_digit_d = Max_digit;
            round_d      = 3'd0;
            incorrect_d  = 3'd0;
            timer_d      = level_load;
            presc_d      = '0;
            result_d     = 2'b00;
            state_d      = ST_PICK;
        end else begin
            case (state_q)
                ST_PICK: begin
                    if (sample < sample_lim) begin
                        target_d = sample;
                        result_d = 2'b00;
                        state_d  = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (timer_q != 7'd0) begin
                            timer_d = timer_q - 7'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (pulse_q) begin
                        latched_d = guess;
                        state_d   = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (latched_q == target_q) begin
                        if (round_q < ROUND_MAX) begin
                            round_d = round_q + 3'd1;
                        end
                        result_d = 2'b11;
                        state_d  = ST_PICK;
                    end else begin
                        if (incorrect_q != 3'd7) begin
                            incorrect_d = incorrect_q + 3'd1;
                        end
                        result_d = (latched_q > target_q) ? 2'b01 : 2'b10;
                        state_d  = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q      <= ST_PICK;
            round_q      <= 3'd0;
            incorrect_q  <= 3'd0;
            timer_q      <= TIMER_INIT;
            target_q     <= 10'd0;
            result_q     <= 2'b00;
            pulse_q      <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            prev_digit_q <= 2'd1;
            presc_q      <= '0;
            latched_q    <= 10'd0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            edge_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            incorrect_q  <= incorrect_d;
            timer_q      <= timer_d;
            target_q     <= target_d;
            result_q     <= result_d;
            pulse_q      <= pulse_d;
            lfsr_q       <= lfsr_d;
            prev_digit_q <= prev_digit_d;
            presc_q      <= presc_d;
            latched_q    <= latched_d;
            sync1_q      <= confirmButton;
            sync2_q      <= sync1_q;
            edge_q       <= sync2_q;
        end
    end

    assign round             = round_q;
    assign incorrect_guesses = incorrect_q;
    assign timer             = timer_q;
    assign target            = target_q;
    assign guess_result      = result_q;
    assign confirm_pulse     = pulse_q;

endmodule
